sync_fifo: RTL
==============

Name: sync_fifo

Overview:
Single-clock, parametrised successor to the team's dual-clock FIFO, for buffering inside one clock domain. Adds an occupancy count, programmable almost-full/almost-empty thresholds, and a selectable first-word-fall-through (FWFT) read mode. Sits between a streaming producer and consumer that share `clk`.

Parameters:
- DW, 32, data width in bits (>=1).
- DEPTH, 16, number of entries; must be a power of two and >=2.
- AF_THRESH, DEPTH-4, almostFull asserts when level >= AF_THRESH.
- AE_THRESH, 4, almostEmpty asserts when level <= AE_THRESH.
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- wrEn  in  1  write request.
- wrData  in  DW  write data.
- rdEn  in  1  read request (pop when FWFT=1).
- rdData  out  DW  read data.
- rdValid  out  1  rdData qualifier.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- almostFull  out  1  level >= AF_THRESH.
- almostEmpty  out  1  level <= AE_THRESH.
- level  out  AW+1  current occupancy, where AW = $clog2(DEPTH).

Behaviour:
- Reset is synchronous, active-low. A rising clk edge with rst_n=0 sets:
  - level=0, pointers=0, empty=1, full=0, almostFull=0, almostEmpty=1.
  - rdValid=0, rdData=0.
  - Memory contents are not reset.
  - wrEn and rdEn are ignored in that cycle.
- Reset mid-operation discards all stored words; the next cycle behaves as an empty FIFO.
- Write accept = wrEn && !full. The word is stored at wrPtr, and wrPtr increments modulo DEPTH.
- Read accept = rdEn && !empty. rdPtr increments modulo DEPTH.
- A write when full is dropped and has no side effect. A read when empty is ignored.
- Simultaneous accepted read and write: level is unchanged and both pointers advance.
  - When full, only the read is accepted that cycle.
  - When empty, only the write is accepted that cycle.
- level is a registered value: next = level + wrAcc - rdAcc.
- All four flags are registered and computed from the next level, so they change on the same edge as level.
- Pointers are AW bits wide and wrap from DEPTH-1 to 0 with no gap.
- Standard mode (FWFT=0):
  - An accepted read in cycle N loads rdData with mem[rdPtr] at the edge ending cycle N.
  - rdValid=1 for exactly cycle N+1.
  - rdData holds its last value until the next accepted read.
- FWFT mode (FWFT=1):
  - rdData = mem[rdPtr] continuously; rdValid = !empty.
  - A word written into an empty FIFO in cycle N appears on rdData with rdValid=1 in cycle N+1, without any rdEn.
  - rdEn acknowledges and pops the head word.
- Elaboration error when any of these fails: DEPTH is a power of two; 1 <= AE_THRESH < AF_THRESH <= DEPTH.

Optional Feature:
- Macro: SYNC_FIFO_ERR_EN.
- When defined, the block adds three ports:
  - errClr  in  1: clears both sticky flags.
  - overflow  out  1: sticky; set by wrEn while full.
  - underflow  out  1: sticky; set by rdEn while empty.
- Both sticky flags reset to 0.
- If errClr and a set event occur in the same cycle, the set wins.
- When not defined, those ports and that logic are absent, and rejected requests are dropped silently.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with wrEn=rdEn=1 -> level=0, empty=1, almostEmpty=1, full=0, almostFull=0, rdValid=0, rdData=0.
- Fill (DW=32, DEPTH=16, AF_THRESH=12, FWFT=0): 17 consecutive writes of 0..16 ->
  - almostFull rises after the 12th accepted write edge.
  - full and level=16 after the 16th.
  - The 17th write (value 16) is dropped; with SYNC_FIFO_ERR_EN, overflow=1 until errClr.
- Drain (FWFT=0): 17 consecutive reads ->
  - rdData = 0..15 in order, each with a one-cycle rdValid pulse one cycle after its rdEn.
  - empty=1 after the 16th read.
  - The extra read leaves rdData=15 and rdValid=0; with SYNC_FIFO_ERR_EN, underflow=1.
- Simultaneous read and write: at level=8, assert wrEn and rdEn together for 20 cycles with incrementing data ->
  - level stays 8 throughout.
  - Both pointers wrap past 15 to 0.
  - Output order matches input order.
- FWFT=1: write 0xA5A5A5A5 into an empty FIFO ->
  - Next cycle: rdData=0xA5A5A5A5, rdValid=1, with rdEn=0.
  - A single rdEn pulse -> empty=1 and rdValid=0 on the following cycle.
- Reset mid-operation: at level=5, drive rst_n=0 for one edge ->
  - level=0, empty=1, rdValid=0 immediately after that edge.
  - The next write of 0x1 reads back 0x1, so stale data is not visible.

Source files
------------

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds and a selectable read mode
// (FWFT=0 registered read, FWFT=1 first-word-fall-through).
// Optional sticky overflow/underflow flags with a clear input are
// compiled in when the macro SYNC_FIFO_ERR_EN is defined.
// Reset is synchronous and active-low; stored words are not cleared.

module sync_fifo #(
   parameter int DW        = 32,
   parameter int DEPTH     = 16,
   parameter int AF_THRESH = DEPTH - 4,
   parameter int AE_THRESH = 4,
   parameter int FWFT      = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wrEn,
   input  logic [DW-1:0]            wrData,
   input  logic                     rdEn,
   output logic [DW-1:0]            rdData,
   output logic                     rdValid,
   output logic                     full,
   output logic                     empty,
   output logic                     almostFull,
   output logic                     almostEmpty,
   output logic [$clog2(DEPTH):0]   level
`ifdef SYNC_FIFO_ERR_EN
   ,
   input  logic                     errClr,
   output logic                     overflow,
   output logic                     underflow
`endif
);

   localparam int AW = $clog2(DEPTH);

   localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0] C_AF   = (AW+1)'(AF_THRESH);
   localparam logic [AW:0] C_AE   = (AW+1)'(AE_THRESH);

   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_badDepth
      $error("sync_fifo: DEPTH must be a power of two and at least 2");
   end

   if ((AE_THRESH < 1) || (AE_THRESH >= AF_THRESH) || (AF_THRESH > DEPTH)) begin : g_badThresh
      $error("sync_fifo: thresholds must satisfy 1 <= AE_THRESH < AF_THRESH <= DEPTH");
   end

   logic [DW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wrPtr;
   logic [AW-1:0] r_rdPtr;
   logic [AW:0]   r_level;
   logic          r_full;
   logic          r_empty;
   logic          r_almostFull;
   logic          r_almostEmpty;

   logic          w_wrAcc;
   logic          w_rdAcc;
   logic [AW:0]   w_levelNext;

   assign w_wrAcc = wrEn && !r_full;
   assign w_rdAcc = rdEn && !r_empty;

   // Occupancy after this edge; a simultaneous read and write cancel out.
   always_comb begin
      w_levelNext = r_level;
      if (w_wrAcc && !w_rdAcc) begin
         w_levelNext = r_level + 1'b1;
      end else if (!w_wrAcc && w_rdAcc) begin
         w_levelNext = r_level - 1'b1;
      end
   end

   // Storage array: written only on an accepted write, never cleared by reset.
   always_ff @(posedge clk) begin
      if (rst_n && w_wrAcc) begin
         r_mem[r_wrPtr] <= wrData;
      end
   end

   // Pointers, level and the four status flags, all derived from the next level.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wrPtr       <= '0;
         r_rdPtr       <= '0;
         r_level       <= '0;
         r_full        <= 1'b0;
         r_empty       <= 1'b1;
         r_almostFull  <= 1'b0;
         r_almostEmpty <= 1'b1;
      end else begin
         if (w_wrAcc) begin
            r_wrPtr <= r_wrPtr + AW'(1);
         end
         if (w_rdAcc) begin
            r_rdPtr <= r_rdPtr + AW'(1);
         end
         r_level       <= w_levelNext;
         r_full        <= (w_levelNext == C_FULL);
         r_empty       <= (w_levelNext == '0);
         r_almostFull  <= (w_levelNext >= C_AF);
         r_almostEmpty <= (w_levelNext <= C_AE);
      end
   end

   assign level       = r_level;
   assign full        = r_full;
   assign empty       = r_empty;
   assign almostFull  = r_almostFull;
   assign almostEmpty = r_almostEmpty;

   if (FWFT == 0) begin : g_std
      logic [DW-1:0] r_rdData;
      logic          r_rdValid;

      // Registered read: data lands one edge after the accepted request and is then held.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            r_rdData  <= '0;
            r_rdValid <= 1'b0;
         end else begin
            r_rdValid <= w_rdAcc;
            if (w_rdAcc) begin
               r_rdData <= r_mem[r_rdPtr];
            end
         end
      end

      assign rdData  = r_rdData;
      assign rdValid = r_rdValid;
   end else begin : g_fwft
      assign rdData  = r_mem[r_rdPtr];
      assign rdValid = !r_empty;
   end

`ifdef SYNC_FIFO_ERR_EN
   logic r_overflow;
   logic r_underflow;

   // Sticky error flags; a new rejected request takes priority over a clear.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (wrEn && r_full) begin
            r_overflow <= 1'b1;
         end else if (errClr) begin
            r_overflow <= 1'b0;
         end
         if (rdEn && r_empty) begin
            r_underflow <= 1'b1;
         end else if (errClr) begin
            r_underflow <= 1'b0;
         end
      end
   end

   assign overflow  = r_overflow;
   assign underflow = r_underflow;
`endif

endmodule
